// File: rtl/reorder_buffer_if.sv
// Issue / writeback / query / commit bundle between the core and the reorder buffer.
// master = core side, slave = reorder buffer.
interface reorder_buffer_if #(
  parameter int ROB_WIDTH = 4,
  parameter int REG_WIDTH = 5
);
  logic                 issueFlag;
  logic [REG_WIDTH-1:0] issueReg;
  logic                 issueBranch;
  logic [ROB_WIDTH-1:0] issueROB;
  logic                 full;

  logic                 wbFlag;
  logic [ROB_WIDTH-1:0] wbROB;
  logic [31:0]          wbData;
  logic                 wbMispredict;
  logic [31:0]          wbTarget;

  logic [ROB_WIDTH-1:0] qry1ROB, qry2ROB;
  logic                 qry1Ready, qry2Ready;
  logic [31:0]          qry1Data, qry2Data;

  logic                 writeFlag;
  logic [ROB_WIDTH-1:0] writeSrc;
  logic [REG_WIDTH-1:0] writeReg;
  logic [31:0]          writeData;
  logic                 clrOut;
  logic [31:0]          clrPC;

  modport master (
    output issueFlag, issueReg, issueBranch,
    input  issueROB, full,
    output wbFlag, wbROB, wbData, wbMispredict, wbTarget,
    output qry1ROB, qry2ROB,
    input  qry1Ready, qry2Ready, qry1Data, qry2Data,
    input  writeFlag, writeSrc, writeReg, writeData, clrOut, clrPC
  );

  modport slave (
    input  issueFlag, issueReg, issueBranch,
    output issueROB, full,
    input  wbFlag, wbROB, wbData, wbMispredict, wbTarget,
    input  qry1ROB, qry2ROB,
    output qry1Ready, qry2Ready, qry1Data, qry2Data,
    output writeFlag, writeSrc, writeReg, writeData, clrOut, clrPC
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: tags issues, collects out-of-order results,
// bypasses operand queries, retires one entry per cycle and flushes on mispredict.
module reorder_buffer #(
  parameter int ROB_WIDTH = 4,
  parameter int REG_WIDTH = 5
) (
  input logic             clkIn,
  input logic             rstIn,
  input logic             rdyIn,
  reorder_buffer_if.slave rob
);
  localparam int DEPTH = 1 << ROB_WIDTH;

  typedef logic [ROB_WIDTH-1:0] tag_t;

  typedef struct packed {
    logic                 busy;
    logic                 ready;
    logic                 is_br;
    logic                 mispred;
    logic [REG_WIDTH-1:0] rd;
    logic [31:0]          data;
    logic [31:0]          target;
  } entry_t;

  entry_t               ent [DEPTH];
  tag_t                 head, tail;
  logic [ROB_WIDTH:0]   count;

  logic                 write_flag, clr;
  tag_t                 write_src;
  logic [REG_WIDTH-1:0] write_reg;
  logic [31:0]          write_data, clr_pc;

  entry_t head_ent;
  logic   retire, flush, do_issue, do_wb;
  logic   byp1, byp2;

  assign head_ent = ent[head];
  assign retire   = head_ent.busy && head_ent.ready;
  assign flush    = retire && head_ent.is_br && head_ent.mispred;
  // count never exceeds DEPTH, so its MSB alone marks a full queue
  assign rob.full     = count[ROB_WIDTH];
  assign rob.issueROB = tail;
  assign do_issue = rob.issueFlag && !count[ROB_WIDTH];
  assign do_wb    = rob.wbFlag && ent[rob.wbROB].busy;

  assign byp1 = rob.wbFlag && (rob.wbROB == rob.qry1ROB);
  assign byp2 = rob.wbFlag && (rob.wbROB == rob.qry2ROB);
  assign rob.qry1Ready = ent[rob.qry1ROB].ready || byp1;
  assign rob.qry2Ready = ent[rob.qry2ROB].ready || byp2;
  assign rob.qry1Data  = byp1 ? rob.wbData : ent[rob.qry1ROB].data;
  assign rob.qry2Data  = byp2 ? rob.wbData : ent[rob.qry2ROB].data;

  assign rob.writeFlag = write_flag;
  assign rob.writeSrc  = write_src;
  assign rob.writeReg  = write_reg;
  assign rob.writeData = write_data;
  assign rob.clrOut    = clr;
  assign rob.clrPC     = clr_pc;

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      write_flag <= 1'b0;
      write_src  <= '0;
      write_reg  <= '0;
      write_data <= '0;
      clr        <= 1'b0;
      clr_pc     <= '0;
    end else if (rdyIn) begin
      write_flag <= retire && (head_ent.rd != '0);
      write_src  <= head;
      write_reg  <= head_ent.rd;
      write_data <= head_ent.data;
      clr        <= flush;
      if (flush) clr_pc <= head_ent.target;

      if (flush) begin
        // same-edge issue and writeback are younger than the branch: dropped
        for (int i = 0; i < DEPTH; i++) begin
          ent[i].busy  <= 1'b0;
          ent[i].ready <= 1'b0;
        end
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_wb) begin
          ent[rob.wbROB].ready   <= 1'b1;
          ent[rob.wbROB].data    <= rob.wbData;
          ent[rob.wbROB].mispred <= rob.wbMispredict;
          ent[rob.wbROB].target  <= rob.wbTarget;
        end
        if (retire) begin
          ent[head].busy <= 1'b0;
          head           <= head + 1'b1;
        end
        if (do_issue) begin
          ent[tail].busy    <= 1'b1;
          ent[tail].ready   <= 1'b0;
          ent[tail].rd      <= rob.issueReg;
          ent[tail].is_br   <= rob.issueBranch;
          ent[tail].mispred <= 1'b0;
          tail              <= tail + 1'b1;
        end
        count <= count + (ROB_WIDTH+1)'(do_issue) - (ROB_WIDTH+1)'(retire);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed test-plan scenarios plus randomized traffic, checked against a
// program-order queue model of in-flight instructions.
module tb_reorder_buffer;
  localparam int RW = 4;
  localparam int GW = 5;
  localparam int D  = 1 << RW;

  logic clkIn = 1'b0;
  logic rstIn = 1'b0;
  logic rdyIn = 1'b0;

  reorder_buffer_if #(.ROB_WIDTH(RW), .REG_WIDTH(GW)) rif ();

  reorder_buffer #(.ROB_WIDTH(RW), .REG_WIDTH(GW)) dut (
    .clkIn(clkIn),
    .rstIn(rstIn),
    .rdyIn(rdyIn),
    .rob  (rif)
  );

  always #5 clkIn = ~clkIn;

  typedef struct {
    logic [RW-1:0] tag;
    logic [GW-1:0] rd;
    bit            br;
    bit            done;
    bit            mis;
    logic [31:0]   data;
    logic [31:0]   tgt;
  } ent_t;

  ent_t          q[$];
  logic [RW-1:0] m_tail;
  bit            m_rdy [D];
  logic [31:0]   m_dat [D];
  bit            e_wf, e_clr;
  logic [RW-1:0] e_src;
  logic [GW-1:0] e_reg;
  logic [31:0]   e_data, e_pc;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_tail = '0;
    for (int i = 0; i < D; i++) m_rdy[i] = 1'b0;
    e_wf = 1'b0; e_clr = 1'b0;
    e_src = '0; e_reg = '0; e_data = '0; e_pc = '0;
  endfunction

  // one clock edge of the reference: oldest entry retires if its result is in
  function automatic void model_step();
    bit   was_full, ret;
    ent_t n;
    if (!rdyIn) return;
    was_full = (q.size() == D);
    ret      = (q.size() > 0) && q[0].done;
    e_wf     = ret && (q[0].rd != 0);
    if (e_wf) begin
      e_src  = q[0].tag;
      e_reg  = q[0].rd;
      e_data = q[0].data;
    end
    e_clr = ret && q[0].br && q[0].mis;
    if (e_clr) begin
      e_pc = q[0].tgt;
      q.delete();
      m_tail = '0;
      for (int i = 0; i < D; i++) m_rdy[i] = 1'b0;
      return;
    end
    if (rif.wbFlag) begin
      foreach (q[i]) begin
        if (q[i].tag == rif.wbROB) begin
          q[i].done = 1'b1;
          q[i].data = rif.wbData;
          q[i].mis  = rif.wbMispredict;
          q[i].tgt  = rif.wbTarget;
          m_rdy[rif.wbROB] = 1'b1;
          m_dat[rif.wbROB] = rif.wbData;
        end
      end
    end
    if (ret) void'(q.pop_front());
    if (rif.issueFlag && !was_full) begin
      n.tag = m_tail; n.rd = rif.issueReg; n.br = rif.issueBranch;
      n.done = 1'b0; n.mis = 1'b0; n.data = '0; n.tgt = '0;
      q.push_back(n);
      m_rdy[m_tail] = 1'b0;
      m_tail = m_tail + 1'b1;
    end
  endfunction

  task automatic chk_qry(input string tag, input logic [RW-1:0] t, input logic rdy, input logic [31:0] dat);
    bit          byp;
    bit          er;
    logic [31:0] ed;
    byp = rif.wbFlag && (rif.wbROB == t);
    er  = m_rdy[t] || byp;
    ed  = byp ? rif.wbData : m_dat[t];
    chk({tag, "_ready"}, rdy, er);
    if (er) chk({tag, "_data"}, dat, ed);
  endtask

  task automatic drive(input bit iss, input logic [GW-1:0] rd, input bit br,
                       input bit wb, input logic [RW-1:0] wtag, input logic [31:0] wdat,
                       input bit mis, input logic [31:0] tgt);
    rif.issueFlag    = iss;
    rif.issueReg     = rd;
    rif.issueBranch  = br;
    rif.wbFlag       = wb;
    rif.wbROB        = wtag;
    rif.wbData       = wdat;
    rif.wbMispredict = mis;
    rif.wbTarget     = tgt;
  endtask

  // entered 1 time unit after a rising edge, leaves 1 time unit after the next
  task automatic cycle();
    #3;
    chk("full", rif.full, q.size() == D);
    chk("issueROB", rif.issueROB, m_tail);
    chk_qry("qry1", rif.qry1ROB, rif.qry1Ready, rif.qry1Data);
    chk_qry("qry2", rif.qry2ROB, rif.qry2Ready, rif.qry2Data);
    model_step();
    @(posedge clkIn);
    #1;
    chk("writeFlag", rif.writeFlag, e_wf);
    if (e_wf) begin
      chk("writeSrc", rif.writeSrc, e_src);
      chk("writeReg", rif.writeReg, e_reg);
      chk("writeData", rif.writeData, e_data);
    end
    chk("clrOut", rif.clrOut, e_clr);
    if (e_clr) chk("clrPC", rif.clrPC, e_pc);
  endtask

  task automatic step(input bit iss, input logic [GW-1:0] rd, input bit br,
                      input bit wb, input logic [RW-1:0] wtag, input logic [31:0] wdat,
                      input bit mis, input logic [31:0] tgt);
    drive(iss, rd, br, wb, wtag, wdat, mis, tgt);
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // reset lands between edges; outputs must clear without waiting for a clock
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rstIn = 1'b0;
    #1;
    model_reset();
    chk("rst_writeFlag", rif.writeFlag, 0);
    chk("rst_writeSrc", rif.writeSrc, 0);
    chk("rst_writeReg", rif.writeReg, 0);
    chk("rst_writeData", rif.writeData, 0);
    chk("rst_clrOut", rif.clrOut, 0);
    chk("rst_clrPC", rif.clrPC, 0);
    chk("rst_full", rif.full, 0);
    chk("rst_issueROB", rif.issueROB, 0);
    @(posedge clkIn);
    #1 rstIn = 1'b1;
  endtask

  initial begin
    int            cand[$];
    int            k;
    bit            iss, wb, mis;
    logic [RW-1:0] wt;

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rif.qry1ROB = '0;
    rif.qry2ROB = '0;
    rdyIn = 1'b1;
    model_reset();
    @(posedge clkIn);
    #1;

    // in-order commit of out-of-order results
    do_reset();
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 32'h33, 0, 0);
    step(0, 0, 0, 1, 0, 32'h11, 0, 0);
    step(0, 0, 0, 1, 1, 32'h22, 0, 0);
    idle(4);

    // fill, overflow attempt, then free one slot across the wrap
    do_reset();
    for (int i = 0; i < D; i++) step(1, GW'(i + 1), 0, 0, 0, 0, 0, 0);
    chk("full_after_fill", rif.full, 1);
    chk("tag_after_fill", rif.issueROB, 0);
    step(1, 31, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'hA0, 0, 0);
    idle(1);
    chk("full_after_commit", rif.full, 0);
    step(1, 4, 0, 0, 0, 0, 0, 0);
    idle(2);

    // mispredicted branch at head flushes the younger completed entry
    do_reset();
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h55, 0, 0);
    step(0, 0, 0, 1, 0, 32'h0, 1, 32'h1000);
    idle(1);
    chk("clr_pulse", rif.clrOut, 1);
    chk("clr_pc", rif.clrPC, 32'h1000);
    idle(2);

    // query bypass, then the same value from storage
    for (int i = 0; i < 4; i++) step(1, 7, 0, 0, 0, 0, 0, 0);
    rif.qry1ROB = 3;
    rif.qry2ROB = 0;
    step(0, 0, 0, 1, 3, 32'hABCD, 0, 0);
    idle(1);

    // stall with a commit pending
    step(0, 0, 0, 1, 0, 32'h100, 0, 0);
    step(0, 0, 0, 1, 1, 32'h101, 0, 0);
    rdyIn = 1'b0;
    idle(3);
    rdyIn = 1'b1;
    idle(3);

    // asynchronous reset mid-stream
    step(1, 9, 0, 0, 0, 0, 0, 0);
    do_reset();
    step(1, 9, 0, 0, 0, 0, 0, 0);
    idle(1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rdyIn = ($urandom_range(0, 9) != 0);
      rif.qry1ROB = RW'($urandom);
      rif.qry2ROB = RW'($urandom);
      iss = ($urandom_range(0, 9) < 6);
      wb  = 1'b0; wt = '0; mis = 1'b0;
      cand.delete();
      foreach (q[i]) if (!q[i].done) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 9) < 7) begin
        k   = cand[$urandom_range(0, cand.size() - 1)];
        wb  = 1'b1;
        wt  = q[k].tag;
        mis = q[k].br && ($urandom_range(0, 3) == 0);
      end else if ($urandom_range(0, 19) == 0) begin
        wb = 1'b1;
        wt = RW'($urandom);
        mis = $urandom_range(0, 1) == 1;
      end
      step(iss, GW'($urandom), $urandom_range(0, 7) == 0, wb, wt, $urandom, mis, $urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    rdyIn = 1'b1;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement queue of 2^ROB_WIDTH entries. Tags each issued instruction with its slot index, collects out-of-order writeback results, and answers renamed-operand queries.
- Retires one instruction per cycle in program order: drives the register-file commit port (writeFlag/writeSrc/writeReg/writeData).
- On a mispredicted branch at the head, raises clrOut to flush the core and supplies the redirect PC.

Parameters:
- ROB_WIDTH, 4, tag width; depth = 2^ROB_WIDTH entries.
- REG_WIDTH, 5, architectural register index width.

Ports:
- clkIn  in  1  clock, rising edge.
- rstIn  in  1  reset, asynchronous, active-low.
- rdyIn  in  1  global ready; low freezes all state and outputs.
- issueFlag  in  1  allocate entry at tail this cycle.
- issueReg  in  REG_WIDTH  destination rd (0 = no write).
- issueBranch  in  1  entry is a predicted control-flow instruction.
- issueROB  out  ROB_WIDTH  tag of the current tail (tag the next issue receives).
- full  out  1  count == 2^ROB_WIDTH.
- wbFlag  in  1  result writeback valid.
- wbROB  in  ROB_WIDTH  tag being written back.
- wbData  in  32  result value.
- wbMispredict  in  1  branch resolved opposite to prediction.
- wbTarget  in  32  correct next PC for mispredicted branch.
- qry1ROB, qry2ROB  in  ROB_WIDTH  renamed operand tags from register-file lookup.
- qry1Ready, qry2Ready  out  1  value for tag is available.
- qry1Data, qry2Data  out  32  value for tag.
- writeFlag  out  1  commit pulse to register file.
- writeSrc  out  ROB_WIDTH  tag of committed entry.
- writeReg  out  REG_WIDTH  committed rd.
- writeData  out  32  committed value.
- clrOut  out  1  flush pulse (mispredict).
- clrPC  out  32  redirect PC, valid with clrOut.

Behaviour:
- Per-entry state: busy, ready, rd, data, isBranch, mispredict, target. Pointers head and tail are ROB_WIDTH bits and wrap modulo depth. count has ROB_WIDTH+1 bits.
- Reset (rstIn=0, asynchronous): head=tail=count=0; all busy/ready=0; writeFlag=clrOut=0; writeSrc/writeReg/writeData/clrPC=0. Outputs: full=0, issueROB=0.
- rdyIn=0: no register changes at all. Registered outputs hold their values. The register file consumes the held commit once rdyIn returns.
- Issue: if issueFlag && !full:
  - slot[tail] gets busy=1, ready=0, rd, isBranch, mispredict=0;
  - tail += 1, count += 1.
  - issueFlag while full is ignored; the issuer must gate on full. full is based on the registered count, so a same-cycle commit does not free a slot for a same-cycle issue.
- Writeback: if wbFlag && busy[wbROB]: ready=1, data=wbData, mispredict=wbMispredict, target=wbTarget. Writeback to a non-busy slot is dropped.
- Commit (registered, 1-cycle latency from head ready):
  - Each edge, writeFlag <= busy[head] && ready[head] && rd!=0.
  - writeSrc/writeReg/writeData are loaded from head.
  - When head is retired: busy=0, head += 1, count -= 1.
  - A writeback arriving at the head at edge N commits at edge N+1; writeFlag is high during cycle N+1..N+2.
  - Entries with rd==0 (including plain branches) retire without writeFlag.
- Mispredict: if the retiring head has isBranch && mispredict:
  - clrOut <= 1 and clrPC <= target for one cycle;
  - on the same edge all busy/ready clear, head=tail=0, count=0.
  - If that branch has rd!=0 (link), writeFlag also pulses with its data.
  - Issue and writeback arriving on the flush edge are discarded.
- Simultaneous issue and commit: count unchanged, both pointers advance. Issue into an empty ROB is legal in the same cycle as the final commit.
- Query (combinational): qryNReady = ready[qryNROB] || (wbFlag && wbROB==qryNROB). qryNData selects wbData on the bypass, else data[qryNROB]. Bypass takes priority.
- Pointer wrap: tail 2^ROB_WIDTH-1 -> 0 and head likewise; the tag sequence is continuous across the wrap.

Test Plan:
- Reset, then issue rd=1,2,3 (tags 0,1,2); writeback tag2=0x33, tag0=0x11, tag1=0x22. Required: writeFlag pulses in order tag0/reg1/0x11, tag1/reg2/0x22, tag2/reg3/0x33, one per cycle, with tag0 committing the cycle after its writeback.
- Issue 16 with no writeback: full=1 and issueROB=0; a 17th issue is ignored. Writeback tag0: after commit, full=0, and the next issue gets tag0 (wrap).
- Issue branch (tag0, rd=0) then rd=5 (tag1); writeback tag1, then tag0 with mispredict and target 0x1000. Required: clrOut=1 for one cycle with clrPC=0x1000, writeFlag never asserts for reg5, and afterwards issueROB=0 and full=0.
- qry1ROB=3 with wbFlag && wbROB=3 && wbData=0xABCD in the same cycle: qry1Ready=1 and qry1Data=0xABCD. The cycle after, with no wb, the values are the same from storage.
- Commit pending, rdyIn held low 3 cycles: writeFlag and writeData frozen, head unchanged. rdyIn returns high: the next entry commits.
- Assert rstIn low mid-stream between clock edges: outputs go to reset values immediately; after release the first issue gets tag0.
